// File: rtl/grayscale_pipe_if.sv
// grayscale_pipe_if: valid/ready RGB pixel stream in, gray stream out.
// master = pixel source/sink side, slave = converter side.
interface grayscale_pipe_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_mode;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_gray;
  logic              out_last;

  modport master (
    output in_valid,
    output in_r,
    output in_g,
    output in_b,
    output in_mode,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_gray,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_r,
    input  in_g,
    input  in_b,
    input  in_mode,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_gray,
    output out_last
  );
endinterface

// File: rtl/grayscale_pipe.sv
// grayscale_pipe: 3-stage RGB-to-gray converter, per-pixel mode,
// global-enable valid/ready pipeline.
module grayscale_pipe #(
  parameter int DATA_W  = 12,
  parameter bit LAST_EN = 1'b1
) (
  input logic        clk,
  input logic        rst,
  grayscale_pipe_if.slave px
);
  localparam int PW = DATA_W + 8;
  localparam int SW = DATA_W + 10;

  localparam logic [DATA_W-1:0] MAX_V = '1;
  localparam logic [PW-1:0] K_R601 = PW'(77);
  localparam logic [PW-1:0] K_G601 = PW'(150);
  localparam logic [PW-1:0] K_B601 = PW'(29);
  localparam logic [PW-1:0] K_MEAN = PW'(85);

  typedef struct packed {
    logic [PW-1:0] tr;
    logic [PW-1:0] tg;
    logic [PW-1:0] tb;
    logic [1:0]    mode;
    logic          last;
  } s1_t;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic [1:0]    mode;
    logic          last;
  } s2_t;

  logic              v1;
  logic              v2;
  logic              v3;
  logic              adv;
  s1_t               s1_d;
  s1_t               s1_q;
  s2_t               s2_d;
  s2_t               s2_q;
  logic [DATA_W-1:0] gray_d;
  logic [DATA_W-1:0] gray_q;
  logic              last_q;
  logic [PW-1:0]     r_x;
  logic [PW-1:0]     g_x;
  logic [PW-1:0]     b_x;
  logic [SW-1:0]     shifted;

  assign adv          = !(v3 && !px.out_ready);
  assign px.in_ready  = adv;
  assign px.out_valid = v3;
  assign px.out_gray  = gray_q;
  assign px.out_last  = LAST_EN && last_q;

  assign r_x = PW'(px.in_r);
  assign g_x = PW'(px.in_g);
  assign b_x = PW'(px.in_b);

  // Mean mode is distributed as 85r+85g+85b so every mode is a 3-term sum.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = px.in_mode;
    s1_d.last = px.in_last;
    unique case (px.in_mode)
      2'd0: begin
        s1_d.tr = r_x >> 2;
        s1_d.tg = g_x >> 1;
        s1_d.tb = b_x >> 2;
      end
      2'd1: begin
        s1_d.tr = r_x * K_R601;
        s1_d.tg = g_x * K_G601;
        s1_d.tb = b_x * K_B601;
      end
      2'd2: begin
        s1_d.tr = r_x * K_MEAN;
        s1_d.tg = g_x * K_MEAN;
        s1_d.tb = b_x * K_MEAN;
      end
      2'd3: begin
        s1_d.tg = g_x;
      end
    endcase
  end

  always_comb begin
    s2_d      = '0;
    s2_d.sum  = SW'(s1_q.tr) + SW'(s1_q.tg) + SW'(s1_q.tb);
    s2_d.mode = s1_q.mode;
    s2_d.last = s1_q.last;
  end

  always_comb begin
    shifted = s2_q.sum;
    if (s2_q.mode == 2'd1 || s2_q.mode == 2'd2) begin
      shifted = s2_q.sum >> 8;
    end
    gray_d = shifted[DATA_W-1:0];
    if (shifted > SW'(MAX_V)) begin
      gray_d = MAX_V;
    end
  end

  // Data registers only load behind a valid; bubbles keep old payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      gray_q <= '0;
      last_q <= 1'b0;
    end else if (adv) begin
      v1 <= px.in_valid;
      v2 <= v1;
      v3 <= v2;
      if (px.in_valid) begin
        s1_q <= s1_d;
      end
      if (v1) begin
        s2_q <= s2_d;
      end
      if (v2) begin
        gray_q <= gray_d;
        last_q <= s2_q.last;
      end
    end
  end
endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe: table vectors, directed corner sequences and a
// randomized run against a queue-based arithmetic reference model.
module tb_grayscale_pipe;
  localparam int DW   = 12;
  localparam int MAXV = 4095;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grayscale_pipe_if #(.DATA_W(DW)) px ();

  grayscale_pipe #(
    .DATA_W (DW),
    .LAST_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .px (px)
  );

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  typedef struct {
    int gray;
    bit last;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int r;
    int g;
    int b;
    int mode;
    int exp;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_gray(input int r, input int g, input int b, input int mode);
    int v;
    case (mode)
      0:       v = r / 4 + g / 2 + b / 4;
      1:       v = (77 * r + 150 * g + 29 * b) / 256;
      2:       v = ((r + g + b) * 85) / 256;
      default: v = g;
    endcase
    if (v > MAXV) v = MAXV;
    return v;
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle.
  bit hold_v = 1'b0;
  int hold_g = 0;
  bit hold_l = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", int'(px.out_valid), 1);
        chk("hold_gray", int'(px.out_gray), hold_g);
        chk("hold_last", int'(px.out_last), int'(hold_l));
      end
      hold_v = px.out_valid && !px.out_ready;
      hold_g = int'(px.out_gray);
      hold_l = px.out_last;
      if (px.out_valid && px.out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL sb_extra: got gray %0d expected no output", px.out_gray);
        end else begin
          e = q.pop_front();
          chk("sb_gray", int'(px.out_gray), e.gray);
          chk("sb_last", int'(px.out_last), int'(e.last));
        end
      end
      if (px.in_valid && px.in_ready) begin
        e.gray = ref_gray(int'(px.in_r), int'(px.in_g), int'(px.in_b), int'(px.in_mode));
        e.last = px.in_last;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b, input int mode, input bit last);
    px.in_valid = 1'b1;
    px.in_r     = DW'(r);
    px.in_g     = DW'(g);
    px.in_b     = DW'(b);
    px.in_mode  = 2'(mode);
    px.in_last  = last;
  endtask

  // Present one pixel to an idle pipe; count edges until out_valid.
  task automatic send_one(input string name, input vec_t v);
    int k;
    px.out_ready = 1'b1;
    drive(v.r, v.g, v.b, v.mode, 1'b0);
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) px.in_valid = 1'b0;
    end while (!px.out_valid && k < 10);
    chk({name, "_lat"}, k, 3);
    chk(name, int'(px.out_gray), v.exp);
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int    exp2[4] = '{1023, 1231, 1359, 0};
    int    got[8];
    int    cyc[8];
    int    n;
    int    pr[8];
    int    pg[8];
    int    pb[8];
    int    pm[8];
    int    sent;
    int    recvd;
    int    held;
    int    out0;
    bit    acc;
    bit    took;
    vec_t  v;

    tbl[0]  = '{4095, 4095, 4095, 0, 4093};
    tbl[1]  = '{4095, 4095, 4095, 1, 4095};
    tbl[2]  = '{4095, 4095, 4095, 2, 4079};
    tbl[3]  = '{0,    0,    0,    2, 0};
    tbl[4]  = '{4095, 0,    0,    0, 1023};
    tbl[5]  = '{4095, 0,    0,    1, 1231};
    tbl[6]  = '{4095, 0,    0,    2, 1359};
    tbl[7]  = '{4095, 0,    0,    3, 0};
    tbl[8]  = '{17,   1234, 99,   3, 1234};
    tbl[9]  = '{0,    4095, 0,    1, 2399};
    tbl[10] = '{0,    4095, 0,    0, 2047};
    tbl[11] = '{0,    0,    4095, 1, 463};
    tbl[12] = '{100,  200,  300,  2, 199};
    tbl[13] = '{3,    3,    3,    0, 1};

    rst          = 1'b1;
    px.in_valid  = 1'b0;
    px.in_r      = '0;
    px.in_g      = '0;
    px.in_b      = '0;
    px.in_mode   = '0;
    px.in_last   = 1'b0;
    px.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", int'(px.out_valid), 0);
    chk("rst_out_gray", int'(px.out_gray), 0);
    chk("rst_out_last", int'(px.out_last), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(px.in_ready), 1);
    tick();

    for (int i = 0; i < 14; i++) begin
      send_one($sformatf("vec%0d", i), tbl[i]);
    end

    // Four modes back-to-back on the same pixel.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (px.out_valid && n < 8) begin
        got[n] = int'(px.out_gray);
        cyc[n] = i;
        n++;
      end
      if (i < 4) drive(4095, 0, 0, i, 1'b0);
      else px.in_valid = 1'b0;
      tick();
    end
    chk("modes_count", n, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("modes_gray%0d", j), got[j], exp2[j]);
      chk($sformatf("modes_b2b%0d", j), cyc[j], cyc[0] + j);
    end

    // Backpressure: 8 pixels, 5-cycle stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      pr[i] = $urandom_range(0, MAXV);
      pg[i] = $urandom_range(0, MAXV);
      pb[i] = $urandom_range(0, MAXV);
      pm[i] = $urandom_range(0, 3);
    end
    sent  = 0;
    recvd = 0;
    held  = 0;
    for (int c = 0; c < 60 && recvd < 8; c++) begin
      px.out_ready = !(c >= 6 && c < 11);
      if (sent < 8) drive(pr[sent], pg[sent], pb[sent], pm[sent], sent == 7);
      else px.in_valid = 1'b0;
      #1;
      acc  = px.in_valid && px.in_ready;
      took = px.out_valid && px.out_ready;
      if (c >= 6 && c < 11) begin
        chk("bp_in_ready", int'(px.in_ready), 0);
        if (c == 6) held = int'(px.out_gray);
        else chk("bp_held", int'(px.out_gray), held);
      end
      if (took) begin
        chk($sformatf("bp_gray%0d", recvd), int'(px.out_gray),
            ref_gray(pr[recvd], pg[recvd], pb[recvd], pm[recvd]));
        chk($sformatf("bp_last%0d", recvd), int'(px.out_last), int'(recvd == 7));
        recvd++;
      end
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_count", recvd, 8);
    px.in_valid  = 1'b0;
    px.out_ready = 1'b1;
    repeat (5) tick();

    // Randomized valid/ready gaps against the scoreboard.
    out0 = n_out;
    sent = 0;
    n    = 0;
    while (sent < 10000 && n < 60000) begin
      px.out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7) begin
        drive($urandom_range(0, MAXV), $urandom_range(0, MAXV),
              $urandom_range(0, MAXV), $urandom_range(0, 3),
              $urandom_range(0, 7) == 0);
      end else begin
        px.in_valid = 1'b0;
      end
      #1;
      if (px.in_valid && px.in_ready) sent++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("rand_sent", sent, 10000);
    px.in_valid  = 1'b0;
    px.out_ready = 1'b1;
    repeat (8) tick();
    chk("rand_drain", q.size(), 0);
    chk("rand_outputs", n_out - out0, 10000);

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) begin
      drive(4095, 4095, 4095, 0, 1'b1);
      tick();
    end
    px.in_valid = 1'b0;
    chk("pre_rst_valid", int'(px.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(px.out_valid), 0);
    chk("rst_async_gray", int'(px.out_gray), 0);
    chk("rst_async_last", int'(px.out_last), 0);
    repeat (2) tick();
    #2;
    rst = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (px.out_valid) n++;
      tick();
    end
    chk("rst_no_stale", n, 0);
    v = '{100, 200, 300, 1, ref_gray(100, 200, 300, 1)};
    send_one("post_rst", v);
    repeat (3) tick();
    chk("final_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
